// File: rtl/bin_to_digits_pkg.sv
// Shared definitions for the binary-to-digits feeder and its display stage.
// FSM encoding, display limits and the off-flag convention.
package bin_to_digits_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_e;

  localparam int MAX_DISPLAY = 9999;
  localparam int NUM_DIGITS  = 4;
  localparam int BCD_W       = 4 * NUM_DIGITS;

  // Off flag value that darkens a digit in the output stage.
  localparam logic OFF_DARK = 1'b1;

endpackage

// File: rtl/bin_to_digits_add3.sv
// Double-dabble nibble correction: adds 3 when the nibble is >= 5.
// Ports: nib_i (4-bit BCD nibble in), nib_o (corrected nibble out).
module bcd_add3 (
  input  logic [3:0] nib_i,
  output logic [3:0] nib_o
);

  always_comb begin
    nib_o = nib_i;
    if (nib_i >= 4'd5) nib_o = nib_i + 4'd3;
  end

endmodule

// File: rtl/bin_to_digits.sv
// Sequential double-dabble binary to 4-digit BCD converter with blank flags.
// Ports: clk/rst, start/bin_in, disp_en, busy/done/ovf, hex_0..3, hex_0..3_off.
module bin_to_digits
  import bin_to_digits_pkg::*;
#(
  parameter int WIDTH         = 14,
  parameter int BLANK_LEADING = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] bin_in,
  input  logic             disp_en,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [3:0]       hex_0,
  output logic [3:0]       hex_1,
  output logic [3:0]       hex_2,
  output logic [3:0]       hex_3,
  output logic             hex_0_off,
  output logic             hex_1_off,
  output logic             hex_2_off,
  output logic             hex_3_off
);

  localparam int   CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic BL = (BLANK_LEADING != 0);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   bin_q, bin_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [BCD_W-1:0]   bcd_adj;
  logic [BCD_W-1:0]   dig_q, dig_d;
  logic               ovfn_q, ovfn_d;
  logic               ovf_q, ovf_d;
  logic               done_q, done_d;
  logic [3:0]         off_q, off_d;

  logic [16:0]        bin_ext;
  logic               sat;
  logic               z3, z2, z1;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_add3
    bcd_add3 u_add3 (
      .nib_i (bcd_q[4*i +: 4]),
      .nib_o (bcd_adj[4*i +: 4])
    );
  end

  // Compare on a widened copy so narrow widths never saturate.
  assign bin_ext = 17'(bin_in);
  assign sat     = (bin_ext > 17'(MAX_DISPLAY));

  assign z3 = (dig_q[15:12] == 4'd0);
  assign z2 = (dig_q[11:8]  == 4'd0);
  assign z1 = (dig_q[7:4]   == 4'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    dig_d   = dig_q;
    ovfn_d  = ovfn_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          bin_d   = sat ? WIDTH'(MAX_DISPLAY) : bin_in;
          ovfn_d  = sat;
          bcd_d   = '0;
          cnt_d   = CW'(WIDTH - 1);
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        bcd_d = {bcd_adj[BCD_W-2:0], bin_q[WIDTH-1]};
        bin_d = {bin_q[WIDTH-2:0], 1'b0};
        if (cnt_q == '0) state_d = ST_DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_DONE: begin
        dig_d   = bcd_q;
        ovf_d   = ovfn_q;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    off_d[0] = !disp_en;
    off_d[1] = !disp_en | (BL & z3 & z2 & z1);
    off_d[2] = !disp_en | (BL & z3 & z2);
    off_d[3] = !disp_en | (BL & z3);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bin_q   <= '0;
      bcd_q   <= '0;
      dig_q   <= '0;
      ovfn_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      off_q   <= {{3{BL & OFF_DARK}}, 1'b0};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      dig_q   <= dig_d;
      ovfn_q  <= ovfn_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      off_q   <= off_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign ovf       = ovf_q;
  assign hex_0     = dig_q[3:0];
  assign hex_1     = dig_q[7:4];
  assign hex_2     = dig_q[11:8];
  assign hex_3     = dig_q[15:12];
  assign hex_0_off = off_q[0];
  assign hex_1_off = off_q[1];
  assign hex_2_off = off_q[2];
  assign hex_3_off = off_q[3];

endmodule

// File: tb/tb_bin_to_digits.sv
// Directed bench for bin_to_digits: vector table plus reset/display sequences.
// Two instances run in lockstep: leading blanking on and off.
module tb_bin_to_digits;

  localparam int W = 14;

  logic clk = 1'b0;
  logic rst, start, disp_en;
  logic [W-1:0] bin_in;

  logic busy_a, done_a, ovf_a;
  logic [3:0] h0_a, h1_a, h2_a, h3_a;
  logic o0_a, o1_a, o2_a, o3_a;
  logic busy_b, done_b, ovf_b;
  logic [3:0] h0_b, h1_b, h2_b, h3_b;
  logic o0_b, o1_b, o2_b, o3_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bin_to_digits #(.WIDTH(W), .BLANK_LEADING(1)) u_bl (
    .clk(clk), .rst(rst), .start(start), .bin_in(bin_in),
    .disp_en(disp_en), .busy(busy_a), .done(done_a), .ovf(ovf_a),
    .hex_0(h0_a), .hex_1(h1_a), .hex_2(h2_a), .hex_3(h3_a),
    .hex_0_off(o0_a), .hex_1_off(o1_a),
    .hex_2_off(o2_a), .hex_3_off(o3_a)
  );

  bin_to_digits #(.WIDTH(W), .BLANK_LEADING(0)) u_nb (
    .clk(clk), .rst(rst), .start(start), .bin_in(bin_in),
    .disp_en(disp_en), .busy(busy_b), .done(done_b), .ovf(ovf_b),
    .hex_0(h0_b), .hex_1(h1_b), .hex_2(h2_b), .hex_3(h3_b),
    .hex_0_off(o0_b), .hex_1_off(o1_b),
    .hex_2_off(o2_b), .hex_3_off(o3_b)
  );

  typedef struct {
    int          val;
    logic [15:0] hex;
    logic        ovf;
    logic [3:0]  off;
    int          pa;
    int          pb;
  } vec_t;

  vec_t vecs[10];

  function automatic logic [15:0] hex_a();
    return {h3_a, h2_a, h1_a, h0_a};
  endfunction

  function automatic logic [15:0] hex_b();
    return {h3_b, h2_b, h1_b, h0_b};
  endfunction

  function automatic logic [3:0] off_a();
    return {o3_a, o2_a, o1_a, o0_a};
  endfunction

  function automatic logic [3:0] off_b();
    return {o3_b, o2_b, o1_b, o0_b};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Start a conversion and watch a fixed window; optional extra
  // start pulses are raised before the given edge numbers.
  task automatic convert(input int val, input int pa, input int pb,
                         output int lat, output int ndone);
    @(posedge clk); #1;
    start  = 1'b1;
    bin_in = W'(val);
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", int'(busy_a), 1);
    lat   = -1;
    ndone = 0;
    for (int n = 1; n <= W + 4; n++) begin
      start = (n == pa || n == pb);
      @(posedge clk); #1;
      if (done_a) begin
        ndone++;
        if (lat < 0) lat = n;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    int lat, nd;

    vecs[0] = '{1234,  16'h1234, 1'b0, 4'b0000, 0, 0};
    vecs[1] = '{7,     16'h0007, 1'b0, 4'b1110, 0, 0};
    vecs[2] = '{0,     16'h0000, 1'b0, 4'b1110, 0, 0};
    vecs[3] = '{16383, 16'h9999, 1'b1, 4'b0000, 0, 0};
    vecs[4] = '{10,    16'h0010, 1'b0, 4'b1100, 0, 0};
    vecs[5] = '{42,    16'h0042, 1'b0, 4'b1100, 3, 8};
    vecs[6] = '{9999,  16'h9999, 1'b0, 4'b0000, 0, 0};
    vecs[7] = '{10000, 16'h9999, 1'b1, 4'b0000, 0, 0};
    vecs[8] = '{305,   16'h0305, 1'b0, 4'b1000, 0, 0};
    vecs[9] = '{100,   16'h0100, 1'b0, 4'b1000, 0, 0};

    rst     = 1'b1;
    start   = 1'b0;
    disp_en = 1'b1;
    bin_in  = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_done", int'(done_a), 0);
    chk("rst_ovf",  int'(ovf_a), 0);
    chk("rst_hex",  int'(hex_a()), 0);
    chk("rst_off",  int'(off_a()), 4'b1110);
    chk("rst_off_nb", int'(off_b()), 0);
    nd = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (done_a) nd++;
    end
    chk("rst_no_done", nd, 0);
    chk("idle_off", int'(off_a()), 4'b1110);

    foreach (vecs[i]) begin
      convert(vecs[i].val, vecs[i].pa, vecs[i].pb, lat, nd);
      chk($sformatf("lat_%0d", vecs[i].val), lat, W + 1);
      chk($sformatf("ndone_%0d", vecs[i].val), nd, 1);
      chk($sformatf("hex_%0d", vecs[i].val),
          int'(hex_a()), int'(vecs[i].hex));
      chk($sformatf("ovf_%0d", vecs[i].val),
          int'(ovf_a), int'(vecs[i].ovf));
      chk($sformatf("off_%0d", vecs[i].val),
          int'(off_a()), int'(vecs[i].off));
      chk($sformatf("hex_nb_%0d", vecs[i].val),
          int'(hex_b()), int'(vecs[i].hex));
      chk($sformatf("off_nb_%0d", vecs[i].val), int'(off_b()), 0);
      chk($sformatf("idle_%0d", vecs[i].val), int'(busy_a), 0);
    end

    convert(1234, 0, 0, lat, nd);
    chk("disp_pre_off", int'(off_a()), 0);
    disp_en = 1'b0;
    @(posedge clk); #1;
    chk("disp_off_bl", int'(off_a()), 4'b1111);
    chk("disp_off_nb", int'(off_b()), 4'b1111);
    chk("disp_hex_held", int'(hex_a()), 16'h1234);
    disp_en = 1'b1;
    @(posedge clk); #1;
    chk("disp_on_bl", int'(off_a()), 0);
    chk("disp_on_hex", int'(hex_a()), 16'h1234);

    convert(16383, 0, 0, lat, nd);
    chk("pre_abort_ovf", int'(ovf_a), 1);
    @(posedge clk); #1;
    start  = 1'b1;
    bin_in = W'(42);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", int'(busy_a), 0);
    chk("abort_done", int'(done_a), 0);
    chk("abort_ovf",  int'(ovf_a), 0);
    chk("abort_hex",  int'(hex_a()), 0);
    chk("abort_off",  int'(off_a()), 4'b1110);
    nd = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done_a) nd++;
    end
    chk("abort_no_done", nd, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
